z_move_sequencer: RTL and testbench

// - Queues Z-axis move commands {signed step count, half-period speed} and issues them one at a time to the Z stepper driver.
// - Drives the driver's start_driving / stepper_step_in / stepper_speed inputs.
// - Tracks completion through stepper_driving and stepper_step_out.
// - Stops and flushes the queue when a move ends early on an endstop.

---
 rtl/z_pkg.sv | 18 +
 rtl/z_cmd_fifo.sv | 63 ++++++
 rtl/z_move_sequencer.sv | 165 ++++++++++++++++
 tb/tb_z_move_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z_pkg.sv
// Shared definitions for the Z-axis move sequencer.
// - STEP_W / SPEED_W : widths of the step count and half-period speed fields
// - ENTRY_W          : width of one queued command, {steps, speed}
// - state_t          : sequencer FSM encoding (IDLE, ISSUE, RUN, HALT)
package z_pkg;

    localparam int STEP_W  = 32;
    localparam int SPEED_W = 32;
    localparam int ENTRY_W = STEP_W + SPEED_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/z_cmd_fifo.sv
// Synchronous command FIFO for queued Z moves.
// Ports:
// - clk, rst     : clock, synchronous active-high reset (empties the FIFO)
// - push, din    : write request and data; taken when not full, or when full
//                  and a pop happens in the same cycle
// - pop          : read request; the head (dout) advances when not empty
// - flush        : synchronous clear, dominates push and pop
// - dout         : current head entry (combinational read)
// - full, empty  : status from pointers carrying one extra wrap bit
module z_cmd_fifo
    import z_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // A full FIFO frees its head slot in the same cycle when popped.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/z_move_sequencer.sv
// Queues Z-axis move commands and issues them one at a time to the stepper
// driver, tracking completion and halting (with queue flush) on early stops.
// Ports:
// - clk, rst                 : clock, synchronous active-high reset
// - cmd_valid/ready/steps/speed : command push interface
// - clear_fault              : pulse that leaves HALT
// - stepper_driving          : driver busy flag
// - stepper_step_out         : driver remaining signed steps
// - stepper_step_in/speed    : registered move parameters to the driver
// - start_driving            : level start request, high only in ISSUE
// - busy, fault              : status
// - fault_remaining          : remaining steps captured at abort
// - moves_done               : completed move count (wraps)
// - state                    : FSM state for observation
// Handshake: a command is taken on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready never depends on cmd_valid.
module z_move_sequencer
    import z_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [STEP_W-1:0]  cmd_steps,
    input  logic [SPEED_W-1:0] cmd_speed,
    input  logic               clear_fault,
    input  logic               stepper_driving,
    input  logic [STEP_W-1:0]  stepper_step_out,
    output logic [STEP_W-1:0]  stepper_step_in,
    output logic [SPEED_W-1:0] stepper_speed,
    output logic               start_driving,
    output logic               busy,
    output logic               fault,
    output logic [STEP_W-1:0]  fault_remaining,
    output logic [15:0]        moves_done,
    output state_t             state
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t               state_next;
    logic [ENTRY_W-1:0]   head;
    logic [STEP_W-1:0]    head_steps;
    logic [SPEED_W-1:0]   head_speed;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic                 load;
    logic                 count_done;
    logic                 cap_timeout;
    logic                 cap_remain;
    logic [CW-1:0]        ack_cnt;

    assign head_steps = head[ENTRY_W-1:SPEED_W];
    assign head_speed = head[SPEED_W-1:0];

    assign cmd_ready     = (state != HALT) && (!fifo_full || pop);
    assign push          = cmd_valid && cmd_ready;
    assign start_driving = (state == ISSUE);
    assign fault         = (state == HALT);
    assign busy          = !fifo_empty || (state != IDLE);

    z_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({cmd_steps, cmd_speed}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load        = 1'b0;
        count_done  = 1'b0;
        cap_timeout = 1'b0;
        cap_remain  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // Magnitude bits zero: the driver would ignore it, so
                    // retire it here without a handshake.
                    if (head_steps[STEP_W-2:0] == '0) begin
                        count_done = 1'b1;
                    end else begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (stepper_driving) begin
                    state_next = RUN;
                end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    cap_timeout = 1'b1;
                    state_next  = HALT;
                end
            end
            RUN: begin
                if (!stepper_driving) begin
                    if (stepper_step_out[STEP_W-2:0] == '0) begin
                        count_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cap_remain = 1'b1;
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                if (clear_fault) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Queue is dropped on the cycle HALT is entered; HALT itself refuses pushes.
    assign flush = (state_next == HALT) && (state != HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            stepper_step_in <= '0;
            stepper_speed   <= '0;
            fault_remaining <= '0;
            moves_done      <= '0;
            ack_cnt         <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                stepper_step_in <= head_steps;
                stepper_speed   <= (head_speed == '0) ? SPEED_W'(1) : head_speed;
            end
            if (cap_timeout) begin
                fault_remaining <= stepper_step_in;
            end else if (cap_remain) begin
                fault_remaining <= stepper_step_out;
            end
            if (count_done) begin
                moves_done <= moves_done + 16'd1;
            end
            if (state == ISSUE) begin
                ack_cnt <= ack_cnt + CW'(1);
            end else begin
                ack_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_z_move_sequencer.sv
// Bench for z_move_sequencer: table of single moves plus hand-written
// sequences for latency, zero entries, timeout, early stop, full queue and
// reset mid-move. A behavioural driver model answers start_driving and pops
// the expected issue queue.
module tb_z_move_sequencer;
    import z_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_steps = '0;
    logic [31:0] cmd_speed = '0;
    logic        clear_fault = 1'b0;
    logic        stepper_driving = 1'b0;
    logic [31:0] stepper_step_out = '0;
    logic [31:0] stepper_step_in;
    logic [31:0] stepper_speed;
    logic        start_driving;
    logic        busy;
    logic        fault;
    logic [31:0] fault_remaining;
    logic [15:0] moves_done;
    state_t      state;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];

    // driver model controls
    bit          drv_refuse = 1'b0;
    bit          drv_hold = 1'b0;
    bit          drv_armed = 1'b1;
    int          drv_len = 3;
    int          drv_cnt = 0;
    logic [31:0] drv_end_remain = '0;

    typedef struct {
        logic [31:0] steps;
        logic [31:0] speed;
        logic [31:0] exp_speed;
        bit          exp_start;
    } vec_t;
    vec_t tbl[6];

    z_move_sequencer #(.DEPTH(8), .ACK_TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_steps        (cmd_steps),
        .cmd_speed        (cmd_speed),
        .clear_fault      (clear_fault),
        .stepper_driving  (stepper_driving),
        .stepper_step_out (stepper_step_out),
        .stepper_step_in  (stepper_step_in),
        .stepper_speed    (stepper_speed),
        .start_driving    (start_driving),
        .busy             (busy),
        .fault            (fault),
        .fault_remaining  (fault_remaining),
        .moves_done       (moves_done),
        .state            (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- driver model + scoreboard pop ----------------
    always @(negedge clk) begin
        if (stepper_driving) begin
            if (!drv_hold) begin
                if (drv_cnt == 0) begin
                    stepper_driving  = 1'b0;
                    stepper_step_out = drv_end_remain;
                end else begin
                    drv_cnt--;
                end
            end
        end else if (start_driving && drv_armed && !drv_refuse) begin
            stepper_driving  = 1'b1;
            drv_armed        = 1'b0;
            drv_cnt          = drv_len;
            stepper_step_out = stepper_step_in;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {stepper_step_in, stepper_speed}, 64'h0);
                if ({stepper_step_in, stepper_speed} == 64'h0) fail_now("unexpected_start_zero");
            end else begin
                chk("issue", {stepper_step_in, stepper_speed}, exp_q.pop_front());
            end
        end
        if (!start_driving) drv_armed = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] s, input logic [31:0] v);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_steps = s;
        cmd_speed = v;
        for (int i = 0; i < 64; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            if (s[30:0] != 31'd0) exp_q.push_back({s, (v == 32'd0) ? 32'd1 : v});
            @(posedge clk);
        end
        #1 cmd_valid = 1'b0;
        if (!ok) fail_now("push_accept");
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_idle");
    endtask

    task automatic wait_start(input int budget);
        bit ok;
        ok = start_driving;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = start_driving;
        end
        if (!ok) fail_now("wait_start");
    endtask

    task automatic wait_fault(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (fault) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_fault");
    endtask

    task automatic wait_driving(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (stepper_driving) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_driving");
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_fault = 1'b1;
        @(posedge clk);
        #1 clear_fault = 1'b0;
    endtask

    // ---------------- test ----------------
    logic [15:0] m0;
    logic [31:0] last_speed;

    initial begin
        tbl[0] = '{32'd7,         32'd3,         32'd3,         1'b1};
        tbl[1] = '{32'hFFFFFFCE,  32'd0,         32'd1,         1'b1};
        tbl[2] = '{32'd0,         32'd7,         32'd0,         1'b0};
        tbl[3] = '{32'h80000000,  32'd5,         32'd0,         1'b0};
        tbl[4] = '{32'd1,         32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1};
        tbl[5] = '{32'hFFFFFFFF,  32'd2,         32'd2,         1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_start", start_driving, 0);
        chk("rst_moves", moves_done, 0);
        chk("rst_step_in", stepper_step_in, 0);
        chk("rst_speed", stepper_speed, 0);
        chk("rst_fault_rem", fault_remaining, 0);
        @(negedge clk);
        rst = 1'b0;

        // latency: +100 @ 4
        push(32'd100, 32'd4);
        chk("lat_start_early", start_driving, 0);
        @(posedge clk);
        #1;
        chk("lat_start_high", start_driving, 1);
        chk("lat_step_in", stepper_step_in, 32'd100);
        chk("lat_speed", stepper_speed, 32'd4);
        @(posedge clk);
        #1;
        chk("lat_start_low", start_driving, 0);
        wait_idle(100);
        chk("lat_moves", moves_done, 1);
        chk("lat_busy", busy, 0);

        // table of single moves
        last_speed = stepper_speed;
        foreach (tbl[i]) begin
            m0 = moves_done;
            push(tbl[i].steps, tbl[i].speed);
            wait_idle(100);
            chk($sformatf("tbl%0d_moves", i), moves_done, m0 + 16'd1);
            if (tbl[i].exp_start) begin
                chk($sformatf("tbl%0d_speed", i), stepper_speed, tbl[i].exp_speed);
                last_speed = tbl[i].exp_speed;
            end else begin
                chk($sformatf("tbl%0d_speed_kept", i), stepper_speed, last_speed);
            end
        end

        // -50, 0, +20 back to back
        m0 = moves_done;
        push(32'hFFFFFFCE, 32'd2);
        push(32'd0, 32'd2);
        push(32'd20, 32'd2);
        wait_idle(200);
        chk("seq_moves", moves_done, m0 + 16'd3);
        chk("seq_last_step_in", stepper_step_in, 32'h00000014);
        chk("seq_exp_empty", exp_q.size(), 0);

        // ack timeout: driver refuses
        drv_refuse = 1'b1;
        m0 = moves_done;
        push(32'd30, 32'd2);
        push(32'd40, 32'd2);
        wait_start(20);
        repeat (15) @(posedge clk);
        #1;
        chk("to_not_yet", fault, 0);
        @(posedge clk);
        #1;
        chk("to_fault", fault, 1);
        chk("to_remaining", fault_remaining, 32'd30);
        chk("to_cmd_ready", cmd_ready, 0);
        chk("to_start_low", start_driving, 0);
        exp_q.delete();
        drv_refuse = 1'b0;
        // clear and push together: clear wins, push refused
        @(negedge clk);
        clear_fault = 1'b1;
        cmd_valid = 1'b1;
        cmd_steps = 32'd77;
        cmd_speed = 32'd1;
        #1;
        chk("clr_push_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        clear_fault = 1'b0;
        cmd_valid = 1'b0;
        chk("clr_fault", fault, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("clr_busy", busy, 0);
        chk("clr_moves", moves_done, m0);

        // early stop at -10
        drv_len = 20;
        drv_end_remain = 32'hFFFFFFF6;
        m0 = moves_done;
        push(32'd50, 32'd1);
        push(32'd60, 32'd1);
        push(32'd70, 32'd1);
        wait_fault(100);
        chk("es_remaining", fault_remaining, 32'hFFFFFFF6);
        chk("es_cmd_ready", cmd_ready, 0);
        chk("es_pending", exp_q.size(), 2);
        exp_q.delete();
        drv_end_remain = '0;
        drv_len = 2;
        pulse_clear();
        repeat (20) @(posedge clk);
        #1;
        chk("es_busy", busy, 0);
        chk("es_moves", moves_done, m0);

        // full queue, push+pop at full, FIFO order
        drv_hold = 1'b1;
        m0 = moves_done;
        push(32'd1, 32'd1);
        wait_driving(20);
        for (int k = 2; k <= 9; k++) begin
            push(k, 32'd1);
            if (k == 8) chk("fill_ready_7", cmd_ready, 1);
            if (k == 9) chk("fill_ready_8", cmd_ready, 0);
        end
        drv_hold = 1'b0;
        push(32'd10, 32'd1);
        chk("fill_ready_after_swap", cmd_ready, 0);
        wait_idle(400);
        chk("fill_moves", moves_done, m0 + 16'd10);
        chk("fill_exp_empty", exp_q.size(), 0);

        // reset during RUN
        drv_hold = 1'b1;
        push(32'd5, 32'd3);
        wait_driving(20);
        push(32'd6, 32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_start", start_driving, 0);
        chk("rr_busy", busy, 0);
        chk("rr_moves", moves_done, 0);
        chk("rr_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        chk("rr_lost", exp_q.size(), 1);
        exp_q.delete();
        drv_hold = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("rr_idle_busy", busy, 0);
        chk("rr_idle_moves", moves_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded bound");
        $fatal(1, "timeout");
    end

endmodule
